// File: rtl/scan_display_ctrl.sv
// ROM scan controller: steps a ROM address at a selectable rate and shows each word on the LEDs.
// Five debounced active-low buttons control pause, speed, direction and single-step.
module scan_display_ctrl #(
  parameter  int ADDR_W     = 8,
  parameter  int DATA_W     = 8,
  parameter  int DEPTH      = 256,
  parameter  int BASE_DIV   = 25_000_000,
  parameter  int N_LVL      = 4,
  parameter  int LVL_INIT   = 0,
  parameter  int DEB_CYCLES = 1_000_000,
  localparam int LVL_W      = (N_LVL > 1) ? $clog2(N_LVL) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_p,
  input  logic              btn_spdup,
  input  logic              btn_spddn,
  input  logic              btn_dir,
  input  logic              btn_step,
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] led_data,
  output logic              paused,
  output logic [LVL_W-1:0]  speed_lvl,
  output logic              dir
);

  localparam int CNT_W  = $clog2(BASE_DIV);
  localparam int DEB_W  = $clog2(DEB_CYCLES);
  localparam int NB     = 5;
  localparam int B_P    = 0;
  localparam int B_UP   = 1;
  localparam int B_DN   = 2;
  localparam int B_DIR  = 3;
  localparam int B_STEP = 4;

  typedef enum logic {ST_RUN = 1'b0, ST_PAUSE = 1'b1} state_t;

  logic [NB-1:0]     w_btn_raw;
  logic [NB-1:0]     r_sync1;
  logic [NB-1:0]     r_sync2;
  logic [NB-1:0]     r_stable;
  logic [NB-1:0]     r_press;
  logic [DEB_W-1:0]  r_deb_cnt [NB];

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] r_led;
  logic [LVL_W-1:0]  r_lvl;
  logic [LVL_W-1:0]  w_lvl_nxt;
  logic              r_dir;
  logic              w_dir_nxt;
  logic [CNT_W-1:0]  r_tick_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  w_period_m1;
  logic              w_tick;
  logic              w_do_step;
  logic              w_cnt_clr;

  assign w_btn_raw = {btn_step, btn_dir, btn_spddn, btn_spdup, btn_p};

  // A press pulse fires only when a debounced level settles low; releases are silent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= '1;
      r_sync2  <= '1;
      r_stable <= '1;
      r_press  <= '0;
      for (int i = 0; i < NB; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < NB; i++) begin
        r_press[i] <= 1'b0;
        if (r_sync2[i] == r_stable[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
          r_stable[i]  <= r_sync2[i];
          r_deb_cnt[i] <= '0;
          r_press[i]   <= ~r_sync2[i];
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  assign w_period_m1 = CNT_W'((BASE_DIV >> r_lvl) - 1);
  assign w_tick      = (r_state == ST_RUN) && (r_tick_cnt == w_period_m1);

  // Next-state logic; the step always uses the direction in force before this cycle's dir press.
  always_comb begin
    w_state_nxt = r_state;
    w_do_step   = 1'b0;
    w_lvl_nxt   = r_lvl;
    w_addr_nxt  = r_addr;
    w_dir_nxt   = r_dir ^ r_press[B_DIR];
    case (r_state)
      ST_RUN: begin
        w_do_step = w_tick;
        if (r_press[B_P]) w_state_nxt = ST_PAUSE;
        else              w_state_nxt = ST_RUN;
      end
      ST_PAUSE: begin
        w_do_step = r_press[B_STEP];
        if (r_press[B_P]) w_state_nxt = ST_RUN;
        else              w_state_nxt = ST_PAUSE;
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_do_step   = 1'b0;
      end
    endcase
    if (r_press[B_UP] && !r_press[B_DN] && (r_lvl != LVL_W'(N_LVL - 1))) begin
      w_lvl_nxt = r_lvl + LVL_W'(1);
    end else if (r_press[B_DN] && !r_press[B_UP] && (r_lvl != LVL_W'(0))) begin
      w_lvl_nxt = r_lvl - LVL_W'(1);
    end else begin
      w_lvl_nxt = r_lvl;
    end
    if (w_do_step) begin
      if (!r_dir) begin
        if (r_addr == ADDR_W'(DEPTH - 1)) w_addr_nxt = '0;
        else                              w_addr_nxt = r_addr + ADDR_W'(1);
      end else begin
        if (r_addr == ADDR_W'(0)) w_addr_nxt = ADDR_W'(DEPTH - 1);
        else                      w_addr_nxt = r_addr - ADDR_W'(1);
      end
    end else begin
      w_addr_nxt = r_addr;
    end
    // Counter restarts on entering/leaving RUN, on a step and on a level change.
    w_cnt_clr = (w_state_nxt != ST_RUN) || (r_state != ST_RUN) || w_tick || (w_lvl_nxt != r_lvl);
    if (w_cnt_clr) w_cnt_nxt = '0;
    else           w_cnt_nxt = r_tick_cnt + CNT_W'(1);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // Datapath registers; led_data follows the ROM one cycle behind addr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_led      <= '0;
      r_lvl      <= LVL_W'(LVL_INIT);
      r_dir      <= 1'b0;
      r_tick_cnt <= '0;
    end else begin
      r_addr     <= w_addr_nxt;
      r_led      <= rom_data;
      r_lvl      <= w_lvl_nxt;
      r_dir      <= w_dir_nxt;
      r_tick_cnt <= w_cnt_nxt;
    end
  end

  assign addr      = r_addr;
  assign led_data  = r_led;
  assign paused    = (r_state == ST_PAUSE);
  assign speed_lvl = r_lvl;
  assign dir       = r_dir;

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Scoreboard bench for scan_display_ctrl: an edge-level behavioural model queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_scan_display_ctrl;

  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 8;
  localparam int DEPTH    = 8;
  localparam int BASE_DIV = 16;
  localparam int N_LVL    = 4;
  localparam int LVL_INIT = 0;
  localparam int DEB      = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [4:0]        btn = 5'b11111;  // [0]=p [1]=spdup [2]=spddn [3]=dir [4]=step
  logic [DATA_W-1:0] rom [DEPTH];
  logic [DATA_W-1:0] rom_data;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] led_data;
  logic              paused;
  logic [1:0]        speed_lvl;
  logic              dir;

  always #10 clk = ~clk;

  assign rom_data = rom[addr];

  scan_display_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_DIV(BASE_DIV),
    .N_LVL(N_LVL), .LVL_INIT(LVL_INIT), .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_p(btn[0]), .btn_spdup(btn[1]), .btn_spddn(btn[2]), .btn_dir(btn[3]), .btn_step(btn[4]),
    .rom_data(rom_data), .addr(addr), .led_data(led_data),
    .paused(paused), .speed_lvl(speed_lvl), .dir(dir)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] led;
    logic              paused;
    logic [1:0]        lvl;
    logic              dir;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   pops  = 0;

  // Reference model state: edge index since reset, scheduled step edge, raw sample history.
  int m_edge, m_addr, m_lvl, m_next;
  bit m_dir, m_run;
  bit m_stable [5];
  bit m_pend   [5];
  bit m_samp   [5][DEB+2];

  function automatic int period(input int lvl);
    return BASE_DIV / (1 << lvl);
  endfunction

  task automatic model_reset();
    m_edge = 0; m_addr = 0; m_lvl = LVL_INIT; m_dir = 1'b0; m_run = 1'b1;
    m_next = period(LVL_INIT);
    for (int b = 0; b < 5; b++) begin
      m_stable[b] = 1'b1;
      m_pend[b]   = 1'b0;
      for (int k = 0; k < DEB + 2; k++) m_samp[b][k] = 1'b1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
      q.delete();
    end else begin
      bit   tick, entered, lchg, differ;
      int   old_addr;
      exp_t e;
      m_edge   = m_edge + 1;
      old_addr = m_addr;
      tick     = m_run && (m_edge == m_next);
      if (m_run ? tick : m_pend[4])
        m_addr = m_dir ? (m_addr + DEPTH - 1) % DEPTH : (m_addr + 1) % DEPTH;
      if (m_pend[3]) m_dir = !m_dir;
      lchg = 1'b0;
      if (m_pend[1] && !m_pend[2] && m_lvl < N_LVL - 1) begin
        m_lvl = m_lvl + 1; lchg = 1'b1;
      end else if (m_pend[2] && !m_pend[1] && m_lvl > 0) begin
        m_lvl = m_lvl - 1; lchg = 1'b1;
      end
      entered = m_pend[0] && !m_run;
      if (m_pend[0]) m_run = !m_run;
      if (m_run && (entered || lchg || tick)) m_next = m_edge + period(m_lvl);
      // Stable level flips once DEB consecutive samples (ignoring the two newest) disagree with it.
      for (int b = 0; b < 5; b++) begin
        for (int k = 0; k < DEB + 1; k++) m_samp[b][k] = m_samp[b][k+1];
        m_samp[b][DEB+1] = btn[b];
        differ = 1'b1;
        for (int k = 0; k < DEB; k++) if (m_samp[b][k] == m_stable[b]) differ = 1'b0;
        m_pend[b] = 1'b0;
        if (differ) begin
          m_stable[b] = !m_stable[b];
          m_pend[b]   = !m_stable[b];
        end
      end
      e.addr   = ADDR_W'(m_addr);
      e.led    = rom[old_addr];
      e.paused = !m_run;
      e.lvl    = 2'(m_lvl);
      e.dir    = m_dir;
      q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (rst_n && q.size() > 0) begin
      exp_t e, g;
      e = q.pop_front();
      g.addr = addr; g.led = led_data; g.paused = paused; g.lvl = speed_lvl; g.dir = dir;
      pops  = pops + 1;
      tests = tests + 1;
      if (g !== e) begin
        fails = fails + 1;
        $display("FAIL outputs t=%0t: got addr=%0d led=%h paused=%b lvl=%0d dir=%b, expected addr=%0d led=%h paused=%b lvl=%0d dir=%b",
                 $time, g.addr, g.led, g.paused, g.lvl, g.dir, e.addr, e.led, e.paused, e.lvl, e.dir);
      end
    end
  end

  task automatic drive(input logic [4:0] lv, input int n);
    btn = lv;
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int got, input int want);
    tests = tests + 1;
    if (got != want) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = DATA_W'($urandom);
    rst_n = 1'b0;
    btn   = 5'b11111;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive(5'b11111, 140);                          // free run, full lap
    drive(5'b11110, 10); drive(5'b11111, 10);      // pause
    repeat (2) begin drive(5'b01111, 8); drive(5'b11111, 8); end
    drive(5'b11110, 10); drive(5'b11111, 40);      // resume
    repeat (4) begin drive(5'b11101, 8); drive(5'b11111, 20); end
    repeat (4) begin drive(5'b11011, 8); drive(5'b11111, 40); end
    drive(5'b11111, 20);
    drive(5'b10111, 8); drive(5'b11111, 60);       // descending
    drive(5'b10111, 8); drive(5'b11111, 40);       // ascending again
    repeat (5) begin drive(5'b11110, 3); drive(5'b11111, 1); end
    drive(5'b11110, 10); drive(5'b11111, 20);      // bounce then one real toggle
    repeat (5) begin drive(5'b11110, 3); drive(5'b11111, 4); end
    drive(5'b11110, 10); drive(5'b11111, 20);      // back to RUN
    drive(5'b11001, 8); drive(5'b11111, 20);       // spdup+spddn together
    for (int it = 0; it < 300; it++) begin
      logic [4:0] lv;
      for (int b = 0; b < 5; b++) lv[b] = ($urandom_range(0, 3) != 0);
      drive(lv, $urandom_range(1, 10));
    end
    drive(5'b11111, 30);
    // Asynchronous reset mid-cycle with btn_p held low through release.
    @(posedge clk);
    btn = 5'b11110;
    #5 rst_n = 1'b0;
    #1;
    check("rst_addr", int'(addr), 0);
    check("rst_led", int'(led_data), 0);
    check("rst_paused", int'(paused), 0);
    check("rst_lvl", int'(speed_lvl), LVL_INIT);
    check("rst_dir", int'(dir), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(5'b11110, 30);
    drive(5'b11111, 60);
    check("scoreboard_pops_min", int'(pops > 1500), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
